// File: rtl/rx_miller_decoder_if.sv
// Bus between the PCD pause detector and the Modified Miller decoder.
// The master drives the synchronised pause line; the slave reports frame events.
interface rx_miller_decoder_if;
    logic pause_n_synchronised;
    logic soc;
    logic eoc;
    logic data;
    logic data_valid;
    logic error;

    modport master (
        output pause_n_synchronised,
        input  soc,
        input  eoc,
        input  data,
        input  data_valid,
        input  error
    );

    modport slave (
        input  pause_n_synchronised,
        output soc,
        output eoc,
        output data,
        output data_valid,
        output error
    );
endinterface

// File: rtl/rx_miller_decoder.sv
// ISO 14443-A Modified Miller decoder for the PCD->PICC direction.
// Pause edges are placed into 128-cycle bit windows (Z near 32, X near 96,
// Y = no edge). Each window resynchronises on its edge. Decoded bits are held
// back one window, because a trailing 0 may turn out to be half of the EOC.
module rx_miller_decoder #(
    parameter int TOL = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rx_miller_decoder_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FRAME} state_t;
    typedef enum logic [1:0] {SEQ_Y, SEQ_X, SEQ_Z} seq_t;

    localparam int Z_LO = 32 - TOL;
    localparam int Z_HI = 32 + TOL;
    localparam int X_LO = 96 - TOL;
    localparam int X_HI = 96 + TOL;

    state_t     state;
    seq_t       cur_seq;
    seq_t       prev_seq;
    logic [6:0] cnt;
    logic       pause_q;
    logic       first_win;
    logic       pend_valid;
    logic       pend_bit;
    logic       emitted;

    logic       pause_edge;
    logic       win_end;
    logic [6:0] edge_pos;
    seq_t       edge_win_seq;
    logic       in_z;
    logic       in_x;
    logic       cls_bit;
    logic       cls_eoc;
    logic       cls_err;
    logic       frame_ends;
    logic       edge_z;
    logic       edge_x;
    logic       edge_err;

    assign pause_edge   = pause_q & ~bus.pause_n_synchronised;
    assign win_end      = (cnt == 7'd127);
    // An edge on the window-end cycle belongs to the next window at position 0.
    assign edge_pos     = win_end ? 7'd0 : cnt;
    assign edge_win_seq = win_end ? SEQ_Y : cur_seq;
    assign in_z         = (int'(edge_pos) >= Z_LO) && (int'(edge_pos) <= Z_HI);
    assign in_x         = (int'(edge_pos) >= X_LO) && (int'(edge_pos) <= X_HI);

    // Classify the window that closes at counter 127 against the previous one.
    always_comb begin
        cls_bit = 1'b0;
        cls_eoc = 1'b0;
        cls_err = 1'b0;
        case (cur_seq)
            SEQ_X:   cls_bit = 1'b1;
            SEQ_Z:   cls_err = (prev_seq == SEQ_X);
            default: cls_eoc = (prev_seq != SEQ_X);
        endcase
    end

    // Decide whether a pause edge inside a frame is a legal Z or X marker.
    always_comb begin
        edge_z     = 1'b0;
        edge_x     = 1'b0;
        edge_err   = 1'b0;
        frame_ends = win_end && !first_win && (cls_err || cls_eoc);
        if (state == ST_FRAME && pause_edge && !frame_ends) begin
            if (edge_win_seq != SEQ_Y) begin
                edge_err = 1'b1;
            end else if (in_z) begin
                edge_z = 1'b1;
            end else if (in_x) begin
                edge_x = 1'b1;
            end else begin
                edge_err = 1'b1;
            end
        end
    end

    // Frame state machine, window counter, pending bit and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_ARMED;
            cnt            <= 7'd0;
            cur_seq        <= SEQ_Y;
            prev_seq       <= SEQ_Z;
            pause_q        <= 1'b0;
            first_win      <= 1'b0;
            pend_valid     <= 1'b0;
            pend_bit       <= 1'b0;
            emitted        <= 1'b0;
            bus.soc        <= 1'b0;
            bus.eoc        <= 1'b0;
            bus.data       <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            bus.soc        <= 1'b0;
            bus.eoc        <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.error      <= 1'b0;
            pause_q        <= bus.pause_n_synchronised;
            case (state)
                ST_ARMED: begin
                    if (bus.pause_n_synchronised) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (pause_edge) begin
                        bus.soc    <= 1'b1;
                        cnt        <= 7'd33;
                        cur_seq    <= SEQ_Z;
                        prev_seq   <= SEQ_Z;
                        first_win  <= 1'b1;
                        pend_valid <= 1'b0;
                        emitted    <= 1'b0;
                        state      <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (edge_err) begin
                        bus.error  <= 1'b1;
                        pend_valid <= 1'b0;
                        state      <= ST_ARMED;
                    end else begin
                        cnt <= cnt + 7'd1;
                        if (win_end) begin
                            if (frame_ends && cls_err) begin
                                bus.error  <= 1'b1;
                                pend_valid <= 1'b0;
                                state      <= ST_ARMED;
                            end else if (frame_ends) begin
                                bus.eoc    <= emitted;
                                bus.error  <= ~emitted;
                                pend_valid <= 1'b0;
                                state      <= ST_ARMED;
                            end else begin
                                if (!first_win) begin
                                    if (pend_valid) begin
                                        bus.data       <= pend_bit;
                                        bus.data_valid <= 1'b1;
                                        emitted        <= 1'b1;
                                    end
                                    pend_bit   <= cls_bit;
                                    pend_valid <= 1'b1;
                                end
                                first_win <= 1'b0;
                                prev_seq  <= cur_seq;
                                cur_seq   <= SEQ_Y;
                            end
                        end
                        if (edge_z) begin
                            cnt     <= 7'd33;
                            cur_seq <= SEQ_Z;
                        end
                        if (edge_x) begin
                            cnt     <= 7'd97;
                            cur_seq <= SEQ_X;
                        end
                    end
                end
                default: state <= ST_ARMED;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_miller_decoder.sv
// Bench for rx_miller_decoder. Frames are built by encoding bit strings into
// Modified Miller sequences; expected events (kind, value, cycle) come from
// the bit string and the edge timing the bench itself scheduled.
module tb_rx_miller_decoder;
    localparam int TOL = 16;
    localparam int SY = 0;
    localparam int SX = 1;
    localparam int SZ = 2;
    localparam int K_SOC   = 0;
    localparam int K_BIT   = 1;
    localparam int K_EOC   = 2;
    localparam int K_ERR   = 3;
    localparam int K_MULTI = 4;

    logic clk;
    logic rst_n;
    rx_miller_decoder_if bus ();

    rx_miller_decoder #(.TOL(TOL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];
    int tx_seq[$];
    int tx_drift[$];
    int win_start[$];
    int edge_t[$];
    int pause_len[$];
    int bits[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event word: kind in [39:36], value in [32], posedge index in [31:0].
    function automatic logic [39:0] ev(input int kind, input bit val, input int t);
        ev = {4'(kind), 3'b000, val, 32'(t)};
    endfunction

    // Record every output pulse with the index of the posedge that produced it.
    always @(negedge clk) begin : monitor
        int n;
        n = int'($time / 10) - 1;
        if ($countones({bus.soc, bus.eoc, bus.data_valid, bus.error}) > 1)
            obs_q.push_back(ev(K_MULTI, 1'b0, n));
        else if (bus.soc === 1'b1)
            obs_q.push_back(ev(K_SOC, 1'b0, n));
        else if (bus.data_valid === 1'b1)
            obs_q.push_back(ev(K_BIT, bus.data, n));
        else if (bus.eoc === 1'b1)
            obs_q.push_back(ev(K_EOC, 1'b0, n));
        else if (bus.error === 1'b1)
            obs_q.push_back(ev(K_ERR, 1'b0, n));
    end

    // Miller encoding: 1 -> X; 0 after 1 -> Y; other 0 -> Z; frame ends with 0 then Y.
    task automatic encode_frame(input int dx, input int dz, input bit rnd);
        int prev;
        int s;
        tx_seq.delete();
        tx_drift.delete();
        tx_seq.push_back(SZ);
        tx_drift.push_back(0);
        prev = 0;
        for (int i = 0; i <= bits.size(); i++) begin
            int b;
            b = (i < bits.size()) ? bits[i] : 0;
            s = (b == 1) ? SX : ((prev == 1) ? SY : SZ);
            tx_seq.push_back(s);
            if (rnd) tx_drift.push_back(int'($urandom_range(2 * (TOL - 2), 0)) - (TOL - 2));
            else     tx_drift.push_back((s == SX) ? dx : dz);
            prev = b;
        end
    endtask

    // Schedule edges window by window (each edge re-anchors its window) and drive them.
    task automatic run_frame(input int stop_win);
        int s;
        int e;
        int u;
        int last;
        logic pn;
        win_start.delete();
        edge_t.delete();
        pause_len.delete();
        @(negedge clk);
        s = int'($time / 10) + 20 - 32;
        foreach (tx_seq[k]) begin
            win_start.push_back(s);
            if (tx_seq[k] == SY) begin
                s = s + 128;
            end else begin
                e = s + ((tx_seq[k] == SX) ? 96 : 32) + tx_drift[k];
                edge_t.push_back(e);
                pause_len.push_back(int'($urandom_range(40, 5)));
                s = (tx_seq[k] == SX) ? e + 32 : e + 96;
            end
        end
        for (int k = 0; k < 4; k++) begin
            win_start.push_back(s);
            s = s + 128;
        end
        last = (stop_win > 0) ? win_start[stop_win] : s;
        do begin
            u = int'($time / 10);
            pn = 1'b1;
            foreach (edge_t[i])
                if (u >= edge_t[i] && u < edge_t[i] + pause_len[i]) pn = 1'b0;
            bus.pause_n_synchronised = pn;
            @(negedge clk);
        end while (u < last);
        #1;
    endtask

    // Bit i of a good frame leaves at the end of window i+2; EOC closes window n+2.
    task automatic expect_good_frame();
        exp_q.push_back(ev(K_SOC, 1'b0, win_start[0] + 32));
        foreach (bits[i]) exp_q.push_back(ev(K_BIT, bit'(bits[i]), win_start[i + 3] - 1));
        exp_q.push_back(ev(K_EOC, 1'b0, win_start[bits.size() + 3] - 1));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pause_n_synchronised = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.pause_n_synchronised = (i % 2 == 0);
            vectors++;
            if ({bus.soc, bus.eoc, bus.data, bus.data_valid, bus.error} !== 5'b00000) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %b expected 00000", i,
                         {bus.soc, bus.eoc, bus.data, bus.data_valid, bus.error});
            end
        end
        bus.pause_n_synchronised = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.soc, bus.eoc, bus.data, bus.data_valid, bus.error} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got %b expected 00000",
                     {bus.soc, bus.eoc, bus.data, bus.data_valid, bus.error});
        end
    endtask

    task automatic test_idle();
        obs_q.delete();
        bus.pause_n_synchronised = 1'b1;
        repeat (1000) @(negedge clk);
        #1;
        vectors++;
        if (obs_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL idle_pulses: got %0d events expected 0", obs_q.size());
        end
    endtask

    task automatic test_fixed_frames();
        obs_q.delete();
        exp_q.delete();
        bits = '{1, 0, 1};
        encode_frame(0, 0, 1'b0);
        run_frame(0);
        expect_good_frame();
        vectors++;
        if (bus.data !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL data_hold_101: got %b expected 1", bus.data);
        end
        bits = '{0, 0};
        encode_frame(0, 0, 1'b0);
        run_frame(0);
        expect_good_frame();
        vectors++;
        if (bus.data !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL data_hold_00: got %b expected 0", bus.data);
        end
        for (int i = 0; i < exp_q.size() || i < obs_q.size(); i++) begin
            vectors++;
            if (i >= exp_q.size() || i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL fixed_frames event %0d: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 40'hx, (i < exp_q.size()) ? exp_q[i] : 40'hx);
            end
        end
    endtask

    task automatic test_random_frames();
        obs_q.delete();
        exp_q.delete();
        for (int f = 0; f < 6; f++) begin
            bits.delete();
            for (int i = 0; i < int'($urandom_range(8, 1)); i++) bits.push_back(int'($urandom_range(1, 0)));
            encode_frame(0, 0, 1'b1);
            run_frame(0);
            expect_good_frame();
        end
        for (int i = 0; i < exp_q.size() || i < obs_q.size(); i++) begin
            vectors++;
            if (i >= exp_q.size() || i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL random_frames event %0d: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 40'hx, (i < exp_q.size()) ? exp_q[i] : 40'hx);
            end
        end
    endtask

    task automatic test_drift();
        obs_q.delete();
        exp_q.delete();
        bits.delete();
        for (int i = 0; i < 20; i++) bits.push_back(int'($urandom_range(1, 0)));
        encode_frame(12, -12, 1'b0);
        run_frame(0);
        expect_good_frame();
        tx_seq = '{SZ, SX};
        tx_drift = '{0, 20};
        run_frame(0);
        exp_q.push_back(ev(K_SOC, 1'b0, win_start[0] + 32));
        exp_q.push_back(ev(K_ERR, 1'b0, edge_t[1]));
        bits = '{1, 1, 0};
        encode_frame(0, 0, 1'b0);
        run_frame(0);
        expect_good_frame();
        for (int i = 0; i < exp_q.size() || i < obs_q.size(); i++) begin
            vectors++;
            if (i >= exp_q.size() || i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL drift event %0d: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 40'hx, (i < exp_q.size()) ? exp_q[i] : 40'hx);
            end
        end
    endtask

    task automatic test_illegal();
        obs_q.delete();
        exp_q.delete();
        tx_seq = '{SZ, SX, SZ};
        tx_drift = '{0, 0, 0};
        run_frame(0);
        exp_q.push_back(ev(K_SOC, 1'b0, win_start[0] + 32));
        exp_q.push_back(ev(K_ERR, 1'b0, win_start[3] - 1));
        tx_seq = '{SZ};
        tx_drift = '{0};
        run_frame(0);
        exp_q.push_back(ev(K_SOC, 1'b0, win_start[0] + 32));
        exp_q.push_back(ev(K_ERR, 1'b0, win_start[2] - 1));
        for (int i = 0; i < exp_q.size() || i < obs_q.size(); i++) begin
            vectors++;
            if (i >= exp_q.size() || i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL illegal event %0d: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 40'hx, (i < exp_q.size()) ? exp_q[i] : 40'hx);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_q.delete();
        exp_q.delete();
        bits = '{1, 0, 0, 1, 1, 0, 1, 0};
        encode_frame(0, 0, 1'b0);
        run_frame(7);
        expect_good_frame();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL pre_reset event %0d: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 40'hx, exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
        bus.pause_n_synchronised = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        bus.pause_n_synchronised = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        vectors++;
        if (obs_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_discard: got %0d events expected 0", obs_q.size());
        end
        bits = '{1};
        encode_frame(0, 0, 1'b0);
        run_frame(0);
        expect_good_frame();
        for (int i = 0; i < exp_q.size() || i < obs_q.size(); i++) begin
            vectors++;
            if (i >= exp_q.size() || i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL post_reset event %0d: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 40'hx, (i < exp_q.size()) ? exp_q[i] : 40'hx);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pause_n_synchronised = 1'b1;
        test_reset();
        test_idle();
        test_fixed_frames();
        test_random_frames();
        test_drift();
        test_illegal();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rx_miller_decoder.md
RX_MILLER_DECODER -- requirements
Module: rx_miller_decoder

Interface
REQ-001 Parameter TOL, default 16: max clocks a pause edge may deviate from its nominal window position.
REQ-002 clk  input  1  13.56 MHz carrier clock; one fc tick per cycle.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pause_n_synchronised  input  1  PCD pause detector output, already synchronised to clk; 0 = pause.
REQ-005 soc  output  1  one-cycle pulse: start of communication detected.
REQ-006 eoc  output  1  one-cycle pulse: end of communication detected.
REQ-007 data  output  1  decoded bit; valid only when data_valid=1.
REQ-008 data_valid  output  1  one-cycle pulse per decoded data bit.
REQ-009 error  output  1  one-cycle pulse: illegal Modified Miller sequence; frame aborted.

Function
REQ-010 Pause edge = pause_n_synchronised registered 1 and current 0; only edges are decoded, pause duration is ignored.
REQ-011 States: IDLE, ARMED, FRAME; ARMED waits for pause_n_synchronised=1, then enters IDLE.
REQ-012 IDLE: pause edge -> soc pulse next cycle, window counter loaded to 33, prev_seq=Z, pending invalid, state FRAME.
REQ-013 Window counter: 7 bits, increments every cycle in FRAME, wraps 127->0; nominal Z edge at 32, X edge at 96.
REQ-014 Edge with counter in [32-TOL, 32+TOL] marks window Z, counter loaded to 33 next cycle (resync).
REQ-015 Edge with counter in [96-TOL, 96+TOL] marks window X, counter loaded to 97 next cycle (resync).
REQ-016 Edge outside both ranges, or second edge in the same window -> error pulse next cycle, state ARMED.
REQ-017 Window without an edge at counter 127 is Y.
REQ-018 Classification at counter 127: X -> bit 1; Z with prev_seq X -> error; Z otherwise -> bit 0; Y with prev_seq X -> bit 0; Y with prev_seq Z or Y -> EOC.
REQ-019 Each decoded bit is held in a one-entry pending register, since a 0 may be the first half of EOC.
REQ-020 At each non-EOC window end: if pending valid, emit it (data, data_valid next cycle); new bit becomes pending.
REQ-021 At EOC: pending 0 discarded, eoc pulse next cycle, state ARMED; if no data bit was ever emitted -> error instead of eoc.
REQ-022 prev_seq updates to current window sequence at each window end.
REQ-023 Latency: bit decoded in window n appears 1 cycle after end of window n+1.
REQ-024 soc, eoc, data_valid, error mutually exclusive in any cycle; all outputs registered.
REQ-025 Pause edge in the same cycle as window end is attributed to the new window (counter value 0).
REQ-026 data holds last emitted value when data_valid=0.

Reset
REQ-027 rst_n low: state ARMED, counter 0, prev_seq Z, pending invalid; soc, eoc, data, data_valid, error all 0.
REQ-028 Reset mid-frame discards the frame with no eoc or error pulse; a pause in progress at release is ignored (ARMED).

Verification
REQ-029 Idle: pause_n_synchronised=1 for 1000 cycles after reset -> no output pulses.
REQ-030 Bits 1,0,1: sequences Z,X,Y,X,Y,Y at 128 clocks each -> soc; data 1,0,1 with data_valid; eoc; no error.
REQ-031 Bits 0,0: sequences Z,Z,Z,Z,Y -> soc; data 0,0; eoc (third Z discarded as EOC half).
REQ-032 Drift: X edges at offset 96+12 and Z edges at 32-12 across 20 bits -> all bits correct via resync; offset 96+20 -> error, next frame decodes cleanly.
REQ-033 Illegal: Z after X (bits 1 then Z) -> error pulse, no eoc; empty frame Z,Y -> error.
REQ-034 Reset asserted mid-frame after 5 bits, frame Z,X,Y sent after release -> only new frame's soc, data 1, eoc observed.
